// File: rtl/int_ctrl18_if.sv
// Port bus between Core18 and int_ctrl18.
// Core drives strobes/address/data; the block returns read data and select.
interface int_ctrl18_if;
  logic        PORT_WR;
  logic        PORT_RD;
  logic [17:0] ADRS;
  logic [17:0] DATAOUT;
  logic [17:0] RD_DATA;
  logic        RD_SEL;

  modport master (
    output PORT_WR, PORT_RD, ADRS, DATAOUT,
    input  RD_DATA, RD_SEL
  );

  modport slave (
    input  PORT_WR, PORT_RD, ADRS, DATAOUT,
    output RD_DATA, RD_SEL
  );
endinterface

// File: rtl/int_ctrl18.sv
// Prioritised 15-source interrupt controller for Core18.
// Sync, edge/level pending, mask, and a port-bus register window.
module int_ctrl18 #(
  parameter logic [17:0] BASE_ADRS   = 18'o000020,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:1] IRQ,
  input  logic        INT_ACK,
  output logic [3:0]  VECTOR,
  int_ctrl18_if.slave bus
);

  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] s;
  logic [15:0] prev_q;
  logic [15:0] mask_q;
  logic [15:0] pend_q;
  logic [15:0] trig_q;
  logic [15:0] mask_d;
  logic [15:0] pend_d;
  logic [15:0] trig_d;
  logic [15:0] wdata;
  logic [15:0] set_v;
  logic [15:0] clr_v;
  logic [15:0] ack_v;
  logic [17:0] off;
  logic        in_win;
  logic [4:0]  sel;
  logic [4:0]  wsel;
  logic        rd_sel;
  logic [17:0] rd_data;
  logic        unused_bits;

  function automatic logic [3:0] encode(
    input logic [15:0] v
  );
    encode = '0;
    for (int i = 1; i < 16; i++)
      if (v[i]) encode = 4'(i);
  endfunction

  // addresses below BASE wrap to a large offset
  assign off    = bus.ADRS - BASE_ADRS;
  assign in_win = off < 18'd5;
  assign wdata  = {bus.DATAOUT[15:1], 1'b0};
  assign s      = sync_q[SYNC_STAGES-1];

  assign unused_bits = ^{bus.DATAOUT[17:16],
                         bus.DATAOUT[0]};

  always_comb begin
    sel = '0;
    for (int k = 0; k < 5; k++)
      sel[k] = in_win && (off[2:0] == 3'(k));
  end

  assign wsel = bus.PORT_WR ? sel : 5'b0;

  always_comb begin
    ack_v = '0;
    if (INT_ACK && VECTOR != 4'd0)
      ack_v[VECTOR] = 1'b1;
  end

  assign mask_d = wsel[0] ? wdata : mask_q;
  assign trig_d = wsel[2] ? wdata : trig_q;
  assign set_v  = (s & ~prev_q)
                | (wsel[4] ? wdata : 16'h0);
  assign clr_v  = (wsel[1] ? wdata : 16'h0)
                | ack_v;

  // set beats clear; level bits just follow s
  assign pend_d =
      (trig_q & (set_v | (pend_q & ~clr_v)))
    | (~trig_q & s);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_q[k] <= '0;
      prev_q <= '0;
      mask_q <= '0;
      pend_q <= '0;
      trig_q <= 16'hFFFE;
      VECTOR <= '0;
    end else begin
      sync_q[0] <= {IRQ, 1'b0};
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
      prev_q <= s;
      mask_q <= mask_d;
      pend_q <= pend_d;
      trig_q <= trig_d;
      VECTOR <= encode(pend_d & mask_d);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_sel  = bus.PORT_RD & in_win;
    if (rd_sel) begin
      unique case (1'b1)
        sel[0]:  rd_data = {2'b0, mask_q};
        sel[1]:  rd_data = {2'b0, pend_q};
        sel[2]:  rd_data = {2'b0, trig_q};
        sel[3]:  rd_data = {14'b0, VECTOR};
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.RD_SEL  = rd_sel;
  assign bus.RD_DATA = rd_data;

endmodule

// File: doc/int_ctrl18.md
Name: int_ctrl18

Overview:
- Prioritised interrupt controller directly upstream of Core18; drives the core's 4-bit VECTOR input.
- Collects 15 external requests (IRQ[15:1]), synchronises them, latches edges or tracks levels, and applies a mask.
- Presents the highest-priority pending source as VECTOR; 0 means no request.
- Software reaches mask/pending/trigger/soft-interrupt registers through the core's port bus (PORT_WR/PORT_RD/ADRS/DATAOUT).

Parameters:
- BASE_ADRS, 18'o000020: port address of register offset 0; the block decodes BASE_ADRS..BASE_ADRS+4.
- SYNC_STAGES, 2: synchroniser depth on IRQ inputs (legal range 2..3).

Ports:
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-high reset (driven from Core18 RESET).
- IRQ  in  15  external requests, bit i = source i (1..15), asynchronous.
- PORT_WR  in  1  port write strobe from core.
- PORT_RD  in  1  port read strobe from core.
- ADRS  in  18  port address from core.
- DATAOUT  in  18  port write data from core.
- INT_ACK  in  1  one-cycle pulse: core has taken the vector currently on VECTOR.
- VECTOR  out  4  highest pending unmasked source, 0 = none.
- RD_DATA  out  18  register read data, combinational, valid when RD_SEL=1.
- RD_SEL  out  1  PORT_RD & address in BASE_ADRS..+4; muxes RD_DATA onto core DATAIN.

Behaviour:
- Register map (bit 0 of all 16-bit fields reads 0, ignores writes; bits 17:16 read 0):
  - +0 MASK: RW, 1 = enabled.
  - +1 PEND: R; write-1-to-clear edge sources.
  - +2 TRIG: RW, 1 = edge, 0 = level.
  - +3 ACTIVE: R, {14'b0, VECTOR}.
  - +4 SWINT: W, write-1-sets PEND (edge sources only); reads 0.
- Reset: on a clock edge with RESET=1, MASK=0, PEND=0, TRIG=all 1s (edge), sync flops=0, edge-history=0, VECTOR=0. Reset mid-operation discards all pending requests. A source held high across reset exit registers exactly one edge.
- Synchroniser: each IRQ bit passes through SYNC_STAGES flops; s = last stage.
- Edge source (TRIG[i]=1):
  - Set term = (s[i] & ~prev[i]) | SWINT write bit i.
  - Clear term = W1C bit i | (INT_ACK & VECTOR==i).
  - Set wins over clear in the same cycle. Pending holds otherwise.
- Level source (TRIG[i]=0): PEND[i] = s[i] each cycle. W1C, SWINT and ACK have no effect; the source must deassert IRQ.
- Priority: higher index wins (15 highest). Masked bits are ignored but still recorded in PEND.
- VECTOR register is loaded every clock with encode(PEND_next & MASK_next). It therefore reflects the same-edge update of PEND and MASK, with no stale cycle after ACK or W1C.
- Latency (SYNC_STAGES=2): IRQ high at sampling edge n gives PEND bit and VECTOR at edge n+2.
- INT_ACK while VECTOR=0 is ignored. ACK clears only the source shown on VECTOR at that edge; a higher source arriving on the same edge appears next cycle as normal.
- Changing TRIG from edge to level on a bit reloads that bit from s on the next edge.
- Port read: RD_DATA is combinational from ADRS and current registers; 0 when RD_SEL=0. Writes take effect at the edge with PORT_WR=1. Addresses outside the window are ignored.

Test Plan:
- Reset/idle: RESET 2 cycles, IRQ=0 -> VECTOR=0, read +0=0, +1=0, +2=18'o177776.
- Single edge: MASK=18'o000400, IRQ[8] rises before edge n -> VECTOR=8 after edge n+2; INT_ACK pulse -> VECTOR=0 next cycle, PEND=0.
- Priority/nesting: MASK=all; IRQ[3] and IRQ[12] pulse together -> VECTOR=12; ACK -> VECTOR=3; ACK -> 0.
- Mask/W1C: MASK=0, IRQ[5] edge -> PEND=18'o000040, VECTOR=0; write MASK bit5 -> VECTOR=5 next cycle; W1C +1 with 18'o000040 -> VECTOR=0.
- Level and SWINT: TRIG bit7=0, IRQ[7] held high -> VECTOR=7, ACK leaves 7; IRQ[7] low -> 0 after 2 edges. SWINT write 18'o000004 -> VECTOR=2.
- Collision: IRQ[4] edge on the same cycle as ACK of vector 4 -> PEND bit4 stays 1, VECTOR=4. RESET asserted while VECTOR=9 -> VECTOR=0 next cycle.
